// File: rtl/redas_array_config_loader.sv
// Double-buffered loader for the stationary operands and broadcast modes of a
// ROWS x COLS ReDAS PE array; a shadow bank fills from a stream, then commits atomically.
module redas_array_config_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [3:0]                      mode_data_movement_in,
    input  logic [4:0]                      mode_calc_pattern_in,
    input  logic                            mode_right_angle_in,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [DATA_WIDTH-1:0]           cfg_data,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] stationary,
    output logic [3:0]                      data_movement_mode,
    output logic [4:0]                      calculation_pattern_mode,
    output logic                            enable_right_angle_movement,
    output logic                            config_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         next_state_s;
    logic [IW-1:0]                  idx_r;

    logic [N-1:0][DATA_WIDTH-1:0]   shadow_r;
    logic [3:0]                     shadow_dm_r;
    logic [4:0]                     shadow_cp_r;
    logic                           shadow_ra_r;

    logic [N-1:0][DATA_WIDTH-1:0]   active_r;
    logic [3:0]                     active_dm_r;
    logic [4:0]                     active_cp_r;
    logic                           active_ra_r;

    logic                           config_valid_r;
    logic                           done_r;
    logic                           busy_r;
    logic                           cfg_ready_r;

    logic                           latch_s;
    logic                           beat_s;
    logic                           last_beat_s;
    logic                           commit_s;
    logic                           busy_s;
    logic                           ready_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort takes priority over any beat in LOAD
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (last_beat_s) begin
                    next_state_s = ST_COMMIT;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_COMMIT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Control strobes and next-cycle handshake/busy flags
    always_comb begin
        latch_s     = 1'b0;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                latch_s = start;
            end
            ST_LOAD: begin
                beat_s      = cfg_valid & ~abort;
                last_beat_s = cfg_valid & ~abort & (idx_r == IW'(N - 1));
            end
            ST_COMMIT: begin
                commit_s = 1'b1;
            end
            default: begin
                latch_s = 1'b0;
            end
        endcase
        ready_s = (next_state_s == ST_LOAD);
        busy_s  = (next_state_s != ST_IDLE);
    end

    // Shadow bank: modes latched at start, operands written row-major per beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r       <= {IW{1'b0}};
            shadow_r    <= '0;
            shadow_dm_r <= 4'd0;
            shadow_cp_r <= 5'd0;
            shadow_ra_r <= 1'b0;
        end else if (latch_s) begin
            idx_r       <= {IW{1'b0}};
            shadow_dm_r <= mode_data_movement_in;
            shadow_cp_r <= mode_calc_pattern_in;
            shadow_ra_r <= mode_right_angle_in;
        end else if (beat_s) begin
            shadow_r[idx_r] <= cfg_data;
            idx_r           <= idx_r + IW'(1);
        end
    end

    // Active bank: only the commit cycle may change what the PEs see
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r       <= '0;
            active_dm_r    <= 4'd0;
            active_cp_r    <= 5'd0;
            active_ra_r    <= 1'b0;
            config_valid_r <= 1'b0;
        end else if (commit_s) begin
            active_r       <= shadow_r;
            active_dm_r    <= shadow_dm_r;
            active_cp_r    <= shadow_cp_r;
            active_ra_r    <= shadow_ra_r;
            config_valid_r <= 1'b1;
        end
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b0;
        end else begin
            done_r      <= commit_s;
            busy_r      <= busy_s;
            cfg_ready_r <= ready_s;
        end
    end

    assign stationary                  = active_r;
    assign data_movement_mode          = active_dm_r;
    assign calculation_pattern_mode    = active_cp_r;
    assign enable_right_angle_movement = active_ra_r;
    assign config_valid                = config_valid_r;
    assign done                        = done_r;
    assign busy                        = busy_r;
    assign cfg_ready                   = cfg_ready_r;

endmodule

// File: tb/tb_redas_array_config_loader.sv
// Self-checking bench for redas_array_config_loader (2x2 array, 8-bit operands):
// a word-count model is compared every cycle, plus hand-computed literal checks.
module tb_redas_array_config_loader;

    localparam int DW = 8;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int N  = R * C;
    localparam int SW = N * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [3:0]    mode_dm_in;
    logic [4:0]    mode_cp_in;
    logic          mode_ra_in;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic [SW-1:0] stationary;
    logic [3:0]    data_movement_mode;
    logic [4:0]    calculation_pattern_mode;
    logic          enable_right_angle_movement;
    logic          config_valid;
    logic          busy;
    logic          done;

    redas_array_config_loader #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .start                       (start),
        .abort                       (abort),
        .mode_data_movement_in       (mode_dm_in),
        .mode_calc_pattern_in        (mode_cp_in),
        .mode_right_angle_in         (mode_ra_in),
        .cfg_valid                   (cfg_valid),
        .cfg_ready                   (cfg_ready),
        .cfg_data                    (cfg_data),
        .stationary                  (stationary),
        .data_movement_mode          (data_movement_mode),
        .calculation_pattern_mode    (calculation_pattern_mode),
        .enable_right_angle_movement (enable_right_angle_movement),
        .config_valid                (config_valid),
        .busy                        (busy),
        .done                        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act !== exp) begin
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt = pass_cnt + 1;
        end
    endtask

    // Model: a load is "open" while fewer than N words have arrived; the cycle
    // after the N-th word the collected words become the visible configuration.
    logic          m_open   = 1'b0;
    logic          m_commit = 1'b0;
    int            m_cnt    = 0;
    logic [DW-1:0] m_words [N];
    logic [3:0]    m_dm     = 4'd0;
    logic [4:0]    m_cp     = 5'd0;
    logic          m_ra     = 1'b0;
    logic [SW-1:0] ex_stat  = '0;
    logic [3:0]    ex_dm    = 4'd0;
    logic [4:0]    ex_cp    = 5'd0;
    logic          ex_ra    = 1'b0;
    logic          ex_cv    = 1'b0;
    logic          ex_done  = 1'b0;

    function automatic logic [SW-1:0] pack_words();
        logic [SW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_words[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_open <= 1'b0; m_commit <= 1'b0; m_cnt <= 0;
            m_dm <= 4'd0; m_cp <= 5'd0; m_ra <= 1'b0;
            ex_stat <= '0; ex_dm <= 4'd0; ex_cp <= 5'd0; ex_ra <= 1'b0;
            ex_cv <= 1'b0; ex_done <= 1'b0;
        end else begin
            ex_done <= m_commit;
            if (m_commit) begin
                ex_stat  <= pack_words();
                ex_dm    <= m_dm;
                ex_cp    <= m_cp;
                ex_ra    <= m_ra;
                ex_cv    <= 1'b1;
                m_commit <= 1'b0;
            end else if (m_open) begin
                if (abort) begin
                    m_open <= 1'b0;
                end else if (cfg_valid) begin
                    m_words[m_cnt] <= cfg_data;
                    m_cnt          <= m_cnt + 1;
                    if (m_cnt == N - 1) begin
                        m_open   <= 1'b0;
                        m_commit <= 1'b1;
                    end
                end
            end else if (start) begin
                m_open <= 1'b1;
                m_cnt  <= 0;
                m_dm   <= mode_dm_in;
                m_cp   <= mode_cp_in;
                m_ra   <= mode_ra_in;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stationary", stationary, ex_stat);
            chk("data_movement_mode", {28'd0, data_movement_mode}, {28'd0, ex_dm});
            chk("calculation_pattern_mode", {27'd0, calculation_pattern_mode}, {27'd0, ex_cp});
            chk("enable_right_angle", {31'd0, enable_right_angle_movement}, {31'd0, ex_ra});
            chk("config_valid", {31'd0, config_valid}, {31'd0, ex_cv});
            chk("done", {31'd0, done}, {31'd0, ex_done});
            chk("busy", {31'd0, busy}, {31'd0, (m_open | m_commit)});
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_open});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input logic [3:0] dm, input logic [4:0] cp, input logic ra);
        start = 1'b1; mode_dm_in = dm; mode_cp_in = cp; mode_ra_in = ra;
        cyc();
        start = 1'b0; mode_dm_in = 4'd0; mode_cp_in = 5'd0; mode_ra_in = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit bubble);
        if (bubble) begin
            cfg_valid = 1'b0;
            cyc();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic load_all(input logic [SW-1:0] words, input bit bubble);
        for (int i = 0; i < N; i++) beat(words[i*DW +: DW], bubble);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        mode_dm_in = 4'd0; mode_cp_in = 5'd0; mode_ra_in = 1'b0;

        // Test 1: reset state
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("t1_stationary", stationary, 32'h0);
        chk("t1_modes", {22'd0, data_movement_mode, calculation_pattern_mode, enable_right_angle_movement}, 32'h0);
        chk("t1_flags", {28'd0, cfg_ready, config_valid, busy, done}, 32'h0);
        rst_n = 1'b1;

        // Test 2: back-to-back load
        begin_load(4'b1010, 5'b10011, 1'b1);
        for (int i = 0; i < N; i++) begin
            chk("t2_ready", {31'd0, cfg_ready}, 32'd1);
            beat(8'h11 * (i + 1), 1'b0);
        end
        chk("t2_commit_ready", {31'd0, cfg_ready}, 32'd0);
        chk("t2_commit_busy", {31'd0, busy}, 32'd1);
        chk("t2_commit_old", stationary, 32'h0);
        cyc();
        chk("t2_stationary", stationary, 32'h44332211);
        chk("t2_dm", {28'd0, data_movement_mode}, 32'hA);
        chk("t2_cp", {27'd0, calculation_pattern_mode}, 32'h13);
        chk("t2_ra", {31'd0, enable_right_angle_movement}, 32'd1);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_cv", {31'd0, config_valid}, 32'd1);
        cyc();
        chk("t2_done_drop", {31'd0, done}, 32'd0);

        // Test 4: reload holds old outputs until the commit edge
        begin_load(4'b0101, 5'b00000, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("t4_hold_stat", stationary, 32'h44332211);
            chk("t4_hold_dm", {28'd0, data_movement_mode}, 32'hA);
            beat(8'hA1 + 8'(i), 1'b0);
        end
        chk("t4_hold_commit", stationary, 32'h44332211);
        cyc();
        chk("t4_stationary", stationary, 32'hA4A3A2A1);
        chk("t4_modes", {22'd0, data_movement_mode, calculation_pattern_mode, enable_right_angle_movement}, {22'd0, 4'b0101, 5'b00000, 1'b0});
        chk("t4_done", {31'd0, done}, 32'd1);
        cyc();

        // Test 3: bubbles between beats
        begin_load(4'b1010, 5'b10011, 1'b1);
        load_all(32'h44332211, 1'b1);
        cyc();
        chk("t3_stationary", stationary, 32'h44332211);
        chk("t3_done", {31'd0, done}, 32'd1);
        cyc();

        // Test 5: abort after two beats, full load, abort on final beat
        begin_load(4'b0011, 5'b00111, 1'b1);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        chk("t5_abort_ready", {31'd0, cfg_ready}, 32'd0);
        cyc();
        chk("t5_abort_done", {31'd0, done}, 32'd0);
        chk("t5_abort_stat", stationary, 32'h44332211);
        chk("t5_abort_cv", {31'd0, config_valid}, 32'd1);
        begin_load(4'b0011, 5'b00111, 1'b1);
        load_all(32'h04030201, 1'b0);
        cyc();
        chk("t5_stationary", stationary, 32'h04030201);
        chk("t5_modes", {22'd0, data_movement_mode, calculation_pattern_mode, enable_right_angle_movement}, {22'd0, 4'b0011, 5'b00111, 1'b1});
        chk("t5_done", {31'd0, done}, 32'd1);
        cyc();
        begin_load(4'b1111, 5'b11111, 1'b0);
        beat(8'h91, 1'b0);
        beat(8'h92, 1'b0);
        beat(8'h93, 1'b0);
        abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h94;
        cyc();
        abort = 1'b0; cfg_valid = 1'b0;
        chk("t5_last_abort_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("t5_last_abort_done", {31'd0, done}, 32'd0);
        chk("t5_last_abort_stat", stationary, 32'h04030201);
        chk("t5_last_abort_dm", {28'd0, data_movement_mode}, 32'h3);

        // Test 6: start ignored in LOAD, start taken in done cycle, reset mid-LOAD
        begin_load(4'b1100, 5'b01010, 1'b1);
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_still_loading", {31'd0, cfg_ready}, 32'd1);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        cyc();
        chk("t6_stationary", stationary, 32'h88776655);
        chk("t6_done", {31'd0, done}, 32'd1);
        begin_load(4'b0001, 5'b00001, 1'b0);
        chk("t6_start_on_done", {31'd0, cfg_ready}, 32'd1);
        beat(8'h12, 1'b0);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_stat", stationary, 32'h0);
        chk("t6_rst_modes", {22'd0, data_movement_mode, calculation_pattern_mode, enable_right_angle_movement}, 32'h0);
        chk("t6_rst_flags", {28'd0, cfg_ready, config_valid, busy, done}, 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("t6_idle_after_rst", {31'd0, busy}, 32'd0);
        cyc();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
